// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and constants for the UART transmit frame path.
// Holds the frame FSM state encoding, parity type codes and the idle line level.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: parity bit for one data word.
// Ports: data (word), par_typ (0 even / 1 odd) -> par_bit (bit to transmit).
module uart_tx_parity
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Odd parity inverts the even-parity bit.
    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame controller driving an external serializer.
// Ports: CLK/RST, Data_Valid, P_DATA, PAR_EN, PAR_TYP, ser_done, ser_data in;
//        ser_load, ser_en, busy, TX_OUT, frame_err out.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_load,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  TX_OUT,
    output logic                  frame_err
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e state_q;
    tx_state_e state_d;

    logic [CW-1:0] bit_cnt_q;
    logic          stop_cnt_q;
    logic          par_en_q;
    logic          par_bit_q;
    logic          par_bit_c;
    logic          line_bit;
    logic          timeout;
    logic          accept;

    uart_tx_parity #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_bit_c)
    );

    // RST gates the strobe so nothing reaches the serializer during reset.
    assign accept   = Data_Valid & (state_q == IDLE) & RST;
    assign ser_load = accept;
    assign timeout  = (bit_cnt_q == LAST_BIT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                state_d = DATA;
            end
            DATA: begin
                if (ser_done | timeout) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                if (stop_cnt_q == STOP_LAST) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        line_bit = IDLE_LEVEL;
        ser_en   = 1'b0;
        unique case (state_q)
            START: begin
                line_bit = 1'b0;
                ser_en   = 1'b1;
            end
            DATA: begin
                line_bit = ser_data;
                // Stop shifting once the last bit is out, by flag or count.
                ser_en   = ~ser_done & ~timeout;
            end
            PARITY: begin
                line_bit = par_bit_q;
            end
            default: begin
                line_bit = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            TX_OUT     <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (state_q == START) begin
                bit_cnt_q <= '0;
            end else if (state_q == DATA) begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
            end

            if (state_q == STOP) begin
                stop_cnt_q <= stop_cnt_q + 1'b1;
            end else begin
                stop_cnt_q <= 1'b0;
            end

            if (accept) begin
                par_en_q  <= PAR_EN;
                par_bit_q <= par_bit_c;
            end

            TX_OUT    <= line_bit;
            busy      <= (state_d != IDLE);
            // Count ran out before the serializer flagged its last bit.
            frame_err <= (state_q == DATA) & timeout & ~ser_done;
        end
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame controller for the UART transmit path. It sits between the parallel data source and the TX line, and drives the existing 8-bit serializer stage.
- It gates and forwards the load strobe, enables shifting, and sequences the start, data, parity and stop bits.
- It computes parity and drives the registered TX line; the serializer supplies the data bits.
- One frame bit per CLK cycle; CLK is the baud-rate clock.

Parameters:
DATA_WIDTH, 8, data bits per frame; must equal the serializer width.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
CLK  input  1  baud clock, rising-edge.
RST  input  1  asynchronous, active-low reset.
Data_Valid  input  1  upstream strobe; P_DATA is valid this cycle.
P_DATA  input  DATA_WIDTH  parallel byte; used here only for parity.
PAR_EN  input  1  1 = insert parity bit; sampled on accept.
PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
ser_done  input  1  serializer flag: last data bit is on ser_data this cycle.
ser_data  input  1  serializer serial output.
ser_load  output  1  load strobe to the serializer's Data_Valid; combinational, Data_Valid & (state==IDLE).
ser_en  output  1  shift enable to the serializer; combinational.
busy  output  1  registered; 1 from the cycle after accept until return to IDLE.
TX_OUT  output  1  registered serial line; idles high.
frame_err  output  1  registered one-cycle pulse: DATA phase ended by timeout, not by ser_done.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, TX_OUT=1, busy=0, frame_err=0, parity and control latches 0.
  - ser_en and ser_load read 0.
  - Reset mid-frame aborts the frame; TX_OUT returns high without waiting for a clock.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - line_bit=1.
  - On Data_Valid: latch PAR_EN and PAR_TYP; latch par_bit = (^P_DATA) ^ PAR_TYP; go to START.
  - Data_Valid outside IDLE is ignored and does not produce ser_load.
- START:
  - line_bit=0.
  - ser_en=1, which shifts data bit 0 onto ser_data.
  - Clear bit_cnt; go to DATA.
- DATA:
  - line_bit=ser_data.
  - ser_en = ~ser_done & (bit_cnt != DATA_WIDTH-1).
  - bit_cnt increments each cycle.
  - Exit when ser_done=1, or when bit_cnt==DATA_WIDTH-1 (timeout). On timeout without ser_done, pulse frame_err next cycle.
  - Exit target: PARITY if the latched PAR_EN=1, else STOP.
  - ser_done and timeout in the same cycle count as a normal exit (no frame_err).
  - Nominal DATA residence: DATA_WIDTH cycles.
- PARITY: line_bit=par_bit; go to STOP.
- STOP:
  - line_bit=1 for STOP_BITS cycles, using a stop counter.
  - Then go to IDLE; busy falls as IDLE is entered.
- TX_OUT is registered: TX_OUT(N+1) = line_bit(N). Line latency is one cycle behind state.
- Frame length from accept to IDLE:
  - 1 + DATA_WIDTH + PAR_EN + STOP_BITS cycles.
  - Example: 11 cycles for 8 data bits, parity on, 1 stop bit.
- Back-to-back frames: a new Data_Valid is accepted in the first IDLE cycle. Minimum one idle-high line cycle between frames.
- ser_done while not in DATA is ignored.

Decomposition:
- Package uart_tx_pkg holds:
  - the typedef enum logic [2:0] tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - constants PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - the localparam IDLE_LEVEL=1'b1.
- One sub-module is natural: uart_tx_parity, a combinational XOR-reduce plus type select, instantiated once.
- The FSM, counters and output register stay in uart_tx_ctrl.
- The top level instantiates uart_tx_ctrl alongside the existing serializer.

Test Plan:
- Reset, then Data_Valid with P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, serializer attached:
  - TX_OUT shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 0 (even parity of A5), then 1.
  - busy is high for 11 cycles; frame_err stays 0.
- P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> parity bit = 0; frame is 11 cycles.
- P_DATA=8'h3C, PAR_EN=0, STOP_BITS=2:
  - no parity slot; two stop cycles; busy is high for 11 cycles.
- Data_Valid pulsed mid-DATA of an active frame -> no ser_load, frame unchanged.
- Data_Valid held in the first IDLE cycle -> second frame starts with exactly one idle-high cycle between frames.
- Stub serializer never asserts ser_done -> DATA exits after 8 cycles and frame_err pulses once.
- RST asserted mid-DATA -> TX_OUT=1 and busy=0 immediately; the next Data_Valid starts a clean frame.
